alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 37 +++
 rtl/alu_arbiter_if.sv | 49 ++++
 rtl/alu_arbiter_rr_arbiter2.sv | 16 +
 rtl/alu_arbiter.sv | 99 +++++++++
 tb/tb_alu_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// The state encoding, op-field layout and flag bit positions live here so the RTL and the bench agree on them.
package alu_arbiter_pkg;

  localparam int OP_W   = 14;
  localparam int FLAG_W = 8;
  localparam int CMD_W  = 4;
  localparam int F3_W   = 3;
  localparam int F7_W   = 7;

  // Bit positions within alu_flags / rsp_flags
  localparam int FLAG_OVERFLOW  = 7;
  localparam int FLAG_EQUAL     = 6;
  localparam int FLAG_NOT_EQUAL = 5;
  localparam int FLAG_GREATER   = 4;
  localparam int FLAG_LESS      = 3;
  localparam int FLAG_U_EQUAL   = 2;
  localparam int FLAG_U_GREATER = 1;
  localparam int FLAG_U_LESS    = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [F3_W-1:0]  funct3;
    logic [F7_W-1:0]  funct7;
  } op_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals around the arbiter.
// slave is the arbiter's view; master is the requester/ALU environment's view.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int WORDSIZE = 64
);

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [WORDSIZE-1:0] req0_a;
  logic [WORDSIZE-1:0] req0_b;
  logic [WORDSIZE-1:0] req1_a;
  logic [WORDSIZE-1:0] req1_b;
  logic [OP_W-1:0]     req0_op;
  logic [OP_W-1:0]     req1_op;

  logic [WORDSIZE-1:0] alu_a;
  logic [WORDSIZE-1:0] alu_b;
  logic [CMD_W-1:0]    alu_cmd;
  logic [F3_W-1:0]     alu_funct3;
  logic [F7_W-1:0]     alu_funct7;
  logic [WORDSIZE-1:0] alu_result;
  logic [FLAG_W-1:0]   alu_flags;

  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [WORDSIZE-1:0] rsp_result;
  logic [FLAG_W-1:0]   rsp_flags;

  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
    output req_ready,
    output alu_a, alu_b, alu_cmd, alu_funct3, alu_funct7,
    input  alu_result, alu_flags,
    output rsp_valid, rsp_result, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
    input  req_ready,
    input  alu_a, alu_b, alu_cmd, alu_funct3, alu_funct7,
    output alu_result, alu_flags,
    input  rsp_valid, rsp_result, rsp_flags,
    output rsp_ready
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-input round-robin grant, purely combinational.
// On contention the requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = i_last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one transaction at a time.
// Flow: IDLE (grant/accept) -> EXEC (drive ALU, capture result) -> RESP (hold until consumed).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);

  state_t              r_state;
  logic                r_last_grant;
  logic                r_grant;
  logic [WORDSIZE-1:0] r_a;
  logic [WORDSIZE-1:0] r_b;
  op_t                 r_op;
  logic [1:0]          r_rsp_valid;
  logic [WORDSIZE-1:0] r_rsp_result;
  logic [FLAG_W-1:0]   r_rsp_flags;

  logic [1:0]          w_grant;
  logic                w_sel;
  logic                w_fire;
  logic                w_rsp_done;
  logic [WORDSIZE-1:0] w_a;
  logic [WORDSIZE-1:0] w_b;
  logic [OP_W-1:0]     w_op;

  rr_arbiter2 u_rr (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Gated by rst so no request can appear accepted while reset is held
  assign bus.req_ready = (r_state == IDLE && !rst) ? w_grant : 2'b00;

  assign w_sel      = w_grant[1];
  assign w_fire     = |(bus.req_valid & bus.req_ready);
  assign w_rsp_done = (r_state == RESP) && bus.rsp_ready[r_grant];
  assign w_a        = w_sel ? bus.req1_a  : bus.req0_a;
  assign w_b        = w_sel ? bus.req1_b  : bus.req0_b;
  assign w_op       = w_sel ? bus.req1_op : bus.req0_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_rsp_valid  <= 2'b00;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_grant <= w_sel;
            r_a     <= w_a;
            r_b     <= w_b;
            r_op    <= op_t'(w_op);
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_result <= bus.alu_result;
          r_rsp_flags  <= bus.alu_flags;
          r_rsp_valid  <= onehot2(r_grant);
          r_state      <= RESP;
        end
        RESP: begin
          // Pointer moves only here, so a waiting requester always gets the next turn
          if (w_rsp_done) begin
            r_rsp_valid  <= 2'b00;
            r_last_grant <= r_grant;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.alu_cmd    = r_op.cmd;
  assign bus.alu_funct3 = r_op.funct3;
  assign bus.alu_funct7 = r_op.funct7;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_flags  = r_rsp_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and an expected-response queue.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 64;
  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd1;

  typedef struct {
    logic         idx;
    logic [W-1:0] res;
    logic [7:0]   flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic tb_last  = 1'b1;
  exp_t sb[$];

  alu_arbiter_if #(.WORDSIZE(W)) bus ();

  alu_arbiter #(.WORDSIZE(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W+7:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [3:0] cmd);
    logic [W-1:0] r;
    logic         ov;
    case (cmd)
      CMD_ADD: begin r = a + b; ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      CMD_SUB: begin r = a - b; ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      default: begin r = a & b; ov = 1'b0; end
    endcase
    return {ov, a == b, a != b, $signed(a) > $signed(b), $signed(a) < $signed(b),
            a == b, a > b, a < b, r};
  endfunction

  always_comb {bus.alu_flags, bus.alu_result} = calc(bus.alu_a, bus.alu_b, bus.alu_cmd);

  function automatic logic [13:0] mk_op(input logic [3:0] cmd);
    return {cmd, 3'b000, 7'b0000000};
  endfunction

  // Advance one clock; any transfer seen before the edge is pushed as an expected response
  task automatic step(input bit drop);
    logic [1:0]   acc;
    logic [W+7:0] v;
    exp_t         e;
    acc = bus.req_valid & bus.req_ready;
    if (acc[0]) begin
      v = calc(bus.req0_a, bus.req0_b, bus.req0_op[13:10]);
      e.idx = 1'b0; e.res = v[W-1:0]; e.flg = v[W+7:W];
      sb.push_back(e);
    end
    if (acc[1]) begin
      v = calc(bus.req1_a, bus.req1_b, bus.req1_op[13:10]);
      e.idx = 1'b1; e.res = v[W-1:0]; e.flg = v[W+7:W];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (drop) bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    tb_last = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.req0_op = '0; bus.req1_op = '0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_req_ready got=%b want=00", bus.req_ready);
    end
    n_checks++;
    if (bus.rsp_valid !== 2'b00 || bus.rsp_result !== '0 || bus.rsp_flags !== 8'h00) begin
      n_fail++; $display("FAIL reset_rsp got valid=%b result=%0h flags=%0h want 0", bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
    end
    n_checks++;
    if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_cmd !== 4'd0 || bus.alu_funct7 !== 7'd0) begin
      n_fail++; $display("FAIL reset_alu got a=%0h b=%0h cmd=%0h want 0", bus.alu_a, bus.alu_b, bus.alu_cmd);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 2'b00;
  endtask

  task automatic test_single_op();
    exp_t e;
    bus.req0_a = 64'd5; bus.req0_b = 64'd3; bus.req0_op = mk_op(CMD_ADD);
    bus.req_valid = 2'b01;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL single_ready got=%b want=01", bus.req_ready);
    end
    step(1'b1);
    n_checks++;
    if (bus.rsp_valid !== 2'b00 || bus.alu_a !== 64'd5 || bus.alu_b !== 64'd3) begin
      n_fail++; $display("FAIL single_exec got valid=%b a=%0d b=%0d want 00/5/3", bus.rsp_valid, bus.alu_a, bus.alu_b);
    end
    step(1'b1);
    n_checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 64'd8) begin
      n_fail++; $display("FAIL single_rsp got valid=%b result=%0d want 01/8", bus.rsp_valid, bus.rsp_result);
    end
    n_checks++;
    if (bus.rsp_flags[FLAG_EQUAL] !== 1'b0 || bus.rsp_flags[FLAG_GREATER] !== 1'b1) begin
      n_fail++; $display("FAIL single_flags got=%b want equal=0 greater=1", bus.rsp_flags);
    end
    bus.rsp_ready = 2'b01;
    if (sb.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL single_sb got=empty want=1 entry");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (e.idx !== 1'b0 || bus.rsp_result !== e.res || bus.rsp_flags !== e.flg) begin
        n_fail++; $display("FAIL single_sb got result=%0h flags=%b want %0h/%b", bus.rsp_result, bus.rsp_flags, e.res, e.flg);
      end
      tb_last = e.idx;
    end
    step(1'b1);
    n_checks++;
    if (bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL single_done got valid=%b want=00", bus.rsp_valid);
    end
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_contention();
    exp_t e;
    logic order[$];
    pulse_reset();
    bus.req0_a = 64'd1; bus.req0_b = 64'd1; bus.req0_op = mk_op(CMD_ADD);
    bus.req1_a = 64'd9; bus.req1_b = 64'd4; bus.req1_op = mk_op(CMD_SUB);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    for (int c = 0; c < 20 && order.size() < 2; c++) begin
      #1;
      if (bus.rsp_valid != 2'b00) begin
        n_checks++;
        if (bus.req_ready !== 2'b00) begin
          n_fail++; $display("FAIL cont_ready_in_resp got=%b want=00", bus.req_ready);
        end
        if (sb.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL cont_sb got=empty want=entry");
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (bus.rsp_valid !== onehot2(e.idx) || bus.rsp_result !== e.res || bus.rsp_flags !== e.flg) begin
            n_fail++; $display("FAIL cont_rsp got valid=%b result=%0d want %b/%0d", bus.rsp_valid, bus.rsp_result, onehot2(e.idx), e.res);
          end
          order.push_back(e.idx);
          tb_last = e.idx;
        end
      end
      step(1'b1);
    end
    n_checks++;
    if (order.size() != 2) begin
      n_fail++; $display("FAIL cont_count got=%0d want=2", order.size());
    end else if (order[0] !== 1'b0 || order[1] !== 1'b1) begin
      n_fail++; $display("FAIL cont_order got=%b,%b want=0,1", order[0], order[1]);
    end
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   seen;
    bus.req0_a = 64'd100; bus.req0_b = 64'd58; bus.req0_op = mk_op(CMD_SUB);
    bus.req1_a = 64'd3;   bus.req1_b = 64'd4;  bus.req1_op = mk_op(CMD_ADD);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL bp_grant got=%b want=01", bus.req_ready);
    end
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      step(1'b1);
      seen = (bus.rsp_valid != 2'b00);
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL bp_timeout got rsp_valid=%b want response within 6 cycles", bus.rsp_valid);
    end
    for (int k = 0; k < 5; k++) begin
      bus.rsp_ready = (k % 2 == 1) ? 2'b10 : 2'b00;
      #1;
      n_checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 64'd42 || bus.req_ready !== 2'b00) begin
        n_fail++; $display("FAIL bp_hold got valid=%b result=%0d ready=%b want 01/42/00", bus.rsp_valid, bus.rsp_result, bus.req_ready);
      end
      step(1'b1);
    end
    bus.rsp_ready = 2'b11;
    for (int c = 0; c < 14 && !(sb.size() == 0 && bus.req_valid == 2'b00 && bus.rsp_valid == 2'b00); c++) begin
      #1;
      if (bus.rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL bp_sb got=empty want=entry");
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (bus.rsp_valid !== onehot2(e.idx) || bus.rsp_result !== e.res || bus.rsp_flags !== e.flg) begin
            n_fail++; $display("FAIL bp_drain got valid=%b result=%0d want %b/%0d", bus.rsp_valid, bus.rsp_result, onehot2(e.idx), e.res);
          end
          tb_last = e.idx;
        end
      end
      step(1'b1);
    end
    n_checks++;
    if (sb.size() != 0 || bus.rsp_valid !== 2'b00 || tb_last !== 1'b1) begin
      n_fail++; $display("FAIL bp_end got pending=%0d valid=%b last=%b want 0/00/1", sb.size(), bus.rsp_valid, tb_last);
    end
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_fairness();
    exp_t e;
    int   got;
    bus.req0_a = 64'd7; bus.req0_b = 64'd2; bus.req0_op = mk_op(CMD_ADD);
    bus.req1_a = 64'd3; bus.req1_b = 64'd8; bus.req1_op = mk_op(CMD_SUB);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      #1;
      if (bus.rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL fair_sb got=empty want=entry");
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (e.idx !== ~tb_last || bus.rsp_valid !== onehot2(e.idx) || bus.rsp_result !== e.res) begin
            n_fail++; $display("FAIL fair_grant got idx=%b valid=%b result=%0h want idx=%b result=%0h", e.idx, bus.rsp_valid, bus.rsp_result, ~tb_last, e.res);
          end
          tb_last = e.idx;
          got++;
          if (got == 8) bus.req_valid = 2'b00;
        end
      end
      step(1'b0);
    end
    n_checks++;
    if (got != 8 || sb.size() != 0) begin
      n_fail++; $display("FAIL fair_count got=%0d pending=%0d want 8/0", got, sb.size());
    end
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_reset_exec();
    bit stray;
    bus.req0_a = 64'd11; bus.req0_b = 64'd22; bus.req0_op = mk_op(CMD_ADD);
    bus.req_valid = 2'b01;
    #1;
    step(1'b1);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00 || bus.rsp_result !== '0 || bus.rsp_flags !== 8'h00) begin
      n_fail++; $display("FAIL rstx_rsp got valid=%b ready=%b result=%0h flags=%0h want 0", bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_flags);
    end
    n_checks++;
    if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_cmd !== 4'd0) begin
      n_fail++; $display("FAIL rstx_alu got a=%0h b=%0h cmd=%0h want 0", bus.alu_a, bus.alu_b, bus.alu_cmd);
    end
    sb.delete();
    tb_last = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_ready = 2'b11;
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.rsp_valid != 2'b00) stray = 1;
      step(1'b1);
    end
    n_checks++;
    if (stray) begin
      n_fail++; $display("FAIL rstx_stray got rsp_valid after reset want none");
    end
    bus.req_valid = 2'b11;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL rstx_grant got=%b want=01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_fairness();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog");
  end

endmodule
